// File: rtl/led_long_decoder.sv
// rtl/led_long_decoder.sv - pulse-width LED line decoder rebuilding four 5-bit symbols; optional PASSCODE_CMP_EN adds EXP_CODE match
module led_long_decoder #(
    parameter int unsigned MIN_PULSE = 2_000_000,
    parameter int unsigned THRESH    = 50_000_000,
    parameter int unsigned MAX_PULSE = 150_000_000,
    parameter int unsigned SYM_GAP   = 100_000_000,
    parameter int unsigned FRAME_GAP = 300_000_000,
    parameter logic [19:0] EXP_CODE  = 20'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LED_signal,
    output logic [4:0] sig1,
    output logic [4:0] sig2,
    output logic [4:0] sig3,
    output logic [4:0] sig4,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy,
    output logic       match
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;

    state_t      state, next_state;
    logic        sync1, sync2, sync3;
    logic        rise, fall;
    logic [31:0] cnt;
    logic [2:0]  bit_cnt, sym_cnt;
    logic [4:0]  sym_sr;
    logic [19:0] frame_sr;
    logic        shift_en, push_en, load_en, clr_en, err_entry;
    logic        bit_val;

    assign rise    = sync2 & ~sync3;
    assign fall    = ~sync2 & sync3;
    assign bit_val = (cnt >= THRESH);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // cnt holds the length of the level that just ended on an edge cycle,
    // otherwise the number of cycles the current level has lasted so far.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        push_en    = 1'b0;
        load_en    = 1'b0;
        unique case (state)
            IDLE: if (rise) next_state = HIGH;
            HIGH: begin
                if (cnt > MAX_PULSE) begin
                    next_state = ERR;
                end else if (fall) begin
                    if (cnt < MIN_PULSE)
                        next_state = (bit_cnt == 3'd0 && sym_cnt == 3'd0) ? IDLE : LOW;
                    else if (bit_cnt == 3'd5)
                        next_state = ERR;
                    else begin
                        shift_en   = 1'b1;
                        next_state = LOW;
                    end
                end
            end
            LOW: begin
                // bit_cnt==0 here means a glitch restarted an already-closed gap
                if (cnt == SYM_GAP && bit_cnt != 3'd0) begin
                    if (bit_cnt != 3'd5 || sym_cnt == 3'd4)
                        next_state = ERR;
                    else begin
                        push_en = 1'b1;
                        if (rise) next_state = HIGH;
                    end
                end else if (cnt == FRAME_GAP) begin
                    if (sym_cnt != 3'd4)
                        next_state = ERR;
                    else begin
                        load_en    = 1'b1;
                        next_state = rise ? HIGH : IDLE;
                    end
                end else if (rise) begin
                    next_state = HIGH;
                end
            end
            ERR: if (!sync2 && cnt >= FRAME_GAP) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        clr_en    = load_en || (next_state == ERR);
        err_entry = (next_state == ERR) && (state != ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            cnt         <= 32'd0;
            bit_cnt     <= 3'd0;
            sym_cnt     <= 3'd0;
            sym_sr      <= 5'd0;
            frame_sr    <= 20'd0;
            sig1        <= 5'd0;
            sig2        <= 5'd0;
            sig3        <= 5'd0;
            sig4        <= 5'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sync1 <= LED_signal;
            sync2 <= sync1;
            sync3 <= sync2;
            if (rise || fall)         cnt <= 32'd1;
            else if (cnt != '1)       cnt <= cnt + 32'd1;
            if (clr_en) begin
                bit_cnt  <= 3'd0;
                sym_cnt  <= 3'd0;
                sym_sr   <= 5'd0;
                frame_sr <= 20'd0;
            end else if (shift_en) begin
                sym_sr  <= {sym_sr[3:0], bit_val};
                bit_cnt <= bit_cnt + 3'd1;
            end else if (push_en) begin
                frame_sr <= {frame_sr[14:0], sym_sr};
                sym_cnt  <= sym_cnt + 3'd1;
                bit_cnt  <= 3'd0;
                sym_sr   <= 5'd0;
            end
            if (load_en) begin
                sig1 <= frame_sr[19:15];
                sig2 <= frame_sr[14:10];
                sig3 <= frame_sr[9:5];
                sig4 <= frame_sr[4:0];
            end
            frame_valid <= load_en;
            frame_err   <= err_entry;
        end
    end

`ifdef PASSCODE_CMP_EN
    always_ff @(posedge clk) begin
        if (rst) match <= 1'b0;
        else     match <= load_en && (frame_sr == EXP_CODE);
    end
`else
    logic unused_exp_code;
    assign unused_exp_code = ^EXP_CODE;
    assign match           = 1'b0;
`endif

endmodule
